des_key_rotator: RTL

DES_KEY_ROTATOR -- requirements
Module: des_key_rotator

---
 rtl/des_key_rotator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/des_key_rotator.sv
`default_nettype none
// ============================================================================
// Module      : des_key_rotator
// Description : DES key-schedule rotator. Applies PC1 to an accepted 64-bit
//               key and then presents the 16 per-round C||D states, one per
//               handshake, to a downstream PC2 stage. Encrypt mode walks
//               CD1..CD16; decrypt mode walks CD16..CD1.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   reset      in   1   synchronous, active-high reset
//   key_in     in  64   DES key, key_in[63] = DES bit 1 (parity bits unused)
//   decrypt    in   1   0 = encrypt schedule, 1 = decrypt schedule
//   key_valid  in   1   key_in/decrypt valid this cycle
//   key_ready  out  1   block is idle and can accept a key
//   cd_out     out 56   C||D round state, cd_out[55] = C bit 1
//   cd_valid   out  1   cd_out holds a valid round state
//   cd_ready   in   1   downstream accepts cd_out this cycle
//   round_idx  out  4   round of cd_out, 0 = round 1 .. 15 = round 16
//   last_round out  1   cd_valid and round_idx == 15
// ============================================================================
module des_key_rotator (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [55:0] cd_out,
  output logic        cd_valid,
  input  logic        cd_ready,
  output logic [3:0]  round_idx,
  output logic        last_round
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // PC1 table packed so that entry i drives cd bit i (entry 55 = DES PC1[1]).
  localparam logic [55:0][6:0] PC1_TABLE = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // Bit r-1 set when round r shifts by two (schedule 1 1 2 2 2 2 2 2 1 2 2 2 2 2 2 1).
  localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [55:0] r_cd;
  logic [55:0] w_cd_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [3:0]  r_round;
  logic [3:0]  w_round_nxt;
  logic        r_decrypt;
  logic        w_decrypt_nxt;

  logic [55:0] w_pc1;
  logic        w_shift_two;

  // PC1 permutation: pure wiring from the key into the load mux.
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    localparam int KEY_BIT = 64 - int'(PC1_TABLE[i]);
    assign w_pc1[i] = key_in[KEY_BIT];
  end

  // The eight parity bits never feed the schedule.
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // Encrypt moves forward to round k+2, so it applies that round's shift.
  // Decrypt undoes the shift that produced the current state CD(16-k),
  // which is the shift of round 16-k.
  always_comb begin
    w_shift_two = 1'b0;
    if (r_decrypt) begin
      w_shift_two = SHIFT_TWO[4'd15 - r_round];
    end else begin
      w_shift_two = SHIFT_TWO[r_round + 4'd1];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cd_nxt      = r_cd;
    w_valid_nxt   = r_valid;
    w_round_nxt   = r_round;
    w_decrypt_nxt = r_decrypt;
    case (r_state)
      IDLE: begin
        if (key_valid) begin
          w_decrypt_nxt = decrypt;
          w_valid_nxt   = 1'b1;
          w_round_nxt   = 4'd0;
          w_state_nxt   = RUN;
          // CD16 equals CD0 (total rotation is 28), so decrypt starts unrotated.
          if (decrypt) begin
            w_cd_nxt = w_pc1;
          end else begin
            w_cd_nxt = {rotl28(w_pc1[55:28], 1'b0), rotl28(w_pc1[27:0], 1'b0)};
          end
        end
      end
      RUN: begin
        if (r_valid && cd_ready) begin
          if (r_round == 4'd15) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_round_nxt = r_round + 4'd1;
            if (r_decrypt) begin
              w_cd_nxt = {rotr28(r_cd[55:28], w_shift_two), rotr28(r_cd[27:0], w_shift_two)};
            end else begin
              w_cd_nxt = {rotl28(r_cd[55:28], w_shift_two), rotl28(r_cd[27:0], w_shift_two)};
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cd      <= 56'd0;
      r_valid   <= 1'b0;
      r_round   <= 4'd0;
      r_decrypt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cd      <= w_cd_nxt;
      r_valid   <= w_valid_nxt;
      r_round   <= w_round_nxt;
      r_decrypt <= w_decrypt_nxt;
    end
  end

  assign key_ready  = (r_state == IDLE);
  assign cd_out     = r_cd;
  assign cd_valid   = r_valid;
  assign round_idx  = r_round;
  assign last_round = r_valid && (r_round == 4'd15);

endmodule
`default_nettype wire
